// File: rtl/slave_spi.sv
// SPI mode-0 slave: synchronizes SCLK/SS/MOSI into clk, shifts WIDTH-bit words both ways.
// Optional macro SLAVE_SPI_LSB_FIRST_EN switches both directions to LSB first (default MSB first).
module slave_spi #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCLK,
  input  logic             SS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_abort
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [2:0]       sclk_sr, ss_sr, mosi_sr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] tx_sh, rx_sh, rx_nxt, hold_dat;
  logic             hold_full;
  logic             first_bit;
  logic             sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic             word_start, rise_act, fall_act, frame_end, abort;

  // Index [1] is the synchronized value, [2] the history flop for edge detection.
  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
  assign ss_fall   = ~ss_sr[1] & ss_sr[2];
  assign ss_rise   = ss_sr[1] & ~ss_sr[2];
  assign tx_ready  = ~hold_full;

  // The shift register holds the word in place; the bit counter picks the bit for MISO,
  // so the falling edge right after a word boundary re-presents the new word's first bit.
`ifdef SLAVE_SPI_LSB_FIRST_EN
  assign idx       = cnt;
  assign rx_nxt    = {mosi_sr[1], rx_sh[WIDTH-1:1]};
  assign first_bit = hold_dat[0];
`else
  assign idx       = LAST - cnt;
  assign rx_nxt    = {rx_sh[WIDTH-2:0], mosi_sr[1]};
  assign first_bit = hold_dat[WIDTH-1];
`endif

  always_comb begin
    state_nxt  = state;
    word_start = 1'b0;
    rise_act   = 1'b0;
    fall_act   = 1'b0;
    frame_end  = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt  = SHIFT;
          word_start = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
          abort     = (cnt != '0);
        end else begin
          rise_act   = sclk_rise;
          fall_act   = sclk_fall;
          word_start = sclk_rise && (cnt == LAST);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sclk_sr     <= 3'b000;
      ss_sr       <= 3'b111;
      mosi_sr     <= 3'b000;
      cnt         <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      rx_data     <= '0;
      hold_dat    <= '0;
      hold_full   <= 1'b0;
      MISO        <= 1'b0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      sclk_sr     <= {sclk_sr[1:0], SCLK};
      ss_sr       <= {ss_sr[1:0], SS};
      mosi_sr     <= {mosi_sr[1:0], MOSI};
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= abort;

      if (rise_act) begin
        cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
        rx_sh <= rx_nxt;
        if (cnt == LAST) begin
          rx_data  <= rx_nxt;
          rx_valid <= 1'b1;
        end
      end
      if (frame_end) cnt <= '0;

      if (fall_act) MISO <= tx_sh[idx];

      if (word_start) begin
        tx_sh       <= hold_full ? hold_dat : '0;
        MISO        <= hold_full & first_bit;
        tx_underrun <= ~hold_full;
        hold_full   <= 1'b0;
      end
      // A handshake in a boundary cycle lands after the boundary has taken the old word.
      if (tx_valid && !hold_full) begin
        hold_dat  <= tx_data;
        hold_full <= 1'b1;
      end

      if (state_nxt == IDLE) MISO <= 1'b0;
    end
  end

endmodule

// File: tb/tb_slave_spi.sv
// Bench for slave_spi: bench-driven SPI master plus a word-level model of rx/tx/pulse expectations.
module tb_slave_spi;
  localparam int W = 8;
`ifdef SLAVE_SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, SCLK, SS, MOSI, MISO;
  logic [W-1:0] tx_data, rx_data;
  logic         tx_valid, tx_ready, rx_valid, tx_underrun, frame_abort;

  slave_spi #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;
  int n_rxv = 0, n_und = 0, n_abt = 0;
  int exp_rxv = 0, exp_und = 0, exp_abt = 0;
  int bits_in = 0, idle_cnt = 0;
  logic [W-1:0] pend_q[$], exp_miso_q[$], exp_rx_q[$];
  logic [W-1:0] last_rx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: every word start consumes the pending tx word, or zeros plus an underrun.
  task automatic model_word_start();
    if (pend_q.size() != 0) exp_miso_q.push_back(pend_q.pop_front());
    else begin
      exp_miso_q.push_back('0);
      exp_und++;
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic offer_tx(input logic [W-1:0] w);
    int t = 0;
    while (!tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("offer_ready", tx_ready, 1);
    tx_valid = 1'b1; tx_data = w;
    @(negedge clk);
    tx_valid = 1'b0;
    pend_q.push_back(w);
  endtask

  task automatic ss_low();
    SS = 1'b0;
    model_word_start();
    half();
  endtask

  task automatic ss_high();
    half();
    SS = 1'b1;
    if (bits_in != 0) exp_abt++;
    bits_in = 0;
    exp_miso_q.delete();
    repeat (12) @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int nbits, input bit refill,
                           input logic [W-1:0] rw, output logic [W-1:0] mw,
                           output logic [W-1:0] raw);
    mw = '0; raw = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = LSB ? w[i] : w[W-1-i];
      half();
      if (LSB) mw[i] = MISO; else mw[W-1-i] = MISO;
      raw = {raw[W-2:0], MISO};
      if (i == nbits - 1 && nbits == W) begin
        exp_rx_q.push_back(w);
        exp_rxv++;
      end
      SCLK = 1'b1;
      if (refill && i == 1) begin
        @(negedge clk);
        chk("refill_ready", tx_ready, 1);
        tx_valid = 1'b1; tx_data = rw;
        @(negedge clk);
        tx_valid = 1'b0;
        pend_q.push_back(rw);
        repeat (6) @(negedge clk);
      end else half();
      SCLK = 1'b0;
    end
    if (nbits == W) begin
      chk("miso_word", mw, (exp_miso_q.size() != 0) ? exp_miso_q.pop_front() : 8'hxx);
      model_word_start();
      bits_in = 0;
    end else bits_in = nbits;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_rx_valid_count"}, n_rxv, exp_rxv);
    chk({tag, "_underrun_count"}, n_und, exp_und);
    chk({tag, "_abort_count"}, n_abt, exp_abt);
    chk({tag, "_rx_outstanding"}, exp_rx_q.size(), 0);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      last_rx  = '0;
      idle_cnt = 0;
    end else begin
      if (tx_underrun) n_und++;
      if (frame_abort) n_abt++;
      if (rx_valid) begin
        n_rxv++;
        if (exp_rx_q.size() == 0) chk("rx_unexpected", 1, 0);
        else begin
          last_rx = exp_rx_q.pop_front();
          chk("rx_data", rx_data, last_rx);
        end
      end else chk("rx_hold", rx_data, last_rx);
      idle_cnt = SS ? idle_cnt + 1 : 0;
      if (idle_cnt >= 5) chk("miso_idle", MISO, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] mw, raw;
    int und0, abt0;
    rst = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_miso", MISO, 0);
    chk("reset_underrun", tx_underrun, 0);
    chk("reset_abort", frame_abort, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Single word with preloaded tx
    offer_tx(8'h3C);
    chk("preload_ready_low", tx_ready, 0);
    ss_low();
    send_word(8'hA5, W, 1'b0, '0, mw, raw);
    chk("w1_miso_literal", mw, 8'h3C);
    ss_high();
    chk("w1_rx_literal", rx_data, 8'hA5);
    chk("w1_tx_ready", tx_ready, 1);
    check_counts("w1");

    // Three back-to-back words with mid-word refills
    offer_tx(8'h11);
    ss_low();
    send_word(8'h01, W, 1'b1, 8'h22, mw, raw);
    chk("b2b_miso0", mw, 8'h11);
    send_word(8'h80, W, 1'b1, 8'h33, mw, raw);
    chk("b2b_miso1", mw, 8'h22);
    send_word(8'hFF, W, 1'b0, '0, mw, raw);
    chk("b2b_miso2", mw, 8'h33);
    ss_high();
    chk("b2b_rx_last", rx_data, 8'hFF);
    check_counts("b2b");

    // Underrun: nothing preloaded
    und0 = n_und;
    ss_low();
    chk("underrun_at_start", n_und - und0, 1);
    send_word(8'h5A, W, 1'b0, '0, mw, raw);
    chk("underrun_miso_zero", mw, 8'h00);
    ss_high();
    chk("underrun_rx", rx_data, 8'h5A);
    check_counts("underrun");

    // Abort after 5 bits, then a full word
    abt0 = n_abt;
    ss_low();
    send_word(8'hF0, 5, 1'b0, '0, mw, raw);
    ss_high();
    chk("abort_pulse", n_abt - abt0, 1);
    chk("abort_rx_kept", rx_data, 8'h5A);
    ss_low();
    send_word(8'hC3, W, 1'b0, '0, mw, raw);
    ss_high();
    chk("abort_next_rx", rx_data, 8'hC3);
    check_counts("abort");

    // Reset mid-word
    offer_tx(8'h99);
    ss_low();
    send_word(8'hFF, 3, 1'b0, '0, mw, raw);
    rst = 1'b1; SS = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_tx_ready", tx_ready, 1);
    chk("midrst_rx_data", rx_data, 0);
    chk("midrst_miso", MISO, 0);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_abort", frame_abort, 0);
    chk("midrst_underrun", tx_underrun, 0);
    rst = 1'b0;
    pend_q.delete(); exp_miso_q.delete(); bits_in = 0;
    repeat (6) @(negedge clk);
    ss_low();
    send_word(8'h7E, W, 1'b0, '0, mw, raw);
    ss_high();
    chk("midrst_rx_next", rx_data, 8'h7E);
    check_counts("midrst");

`ifdef SLAVE_SPI_LSB_FIRST_EN
    offer_tx(8'h80);
    ss_low();
    send_word(8'h01, W, 1'b0, '0, mw, raw);
    chk("lsb_miso_sequence", raw, 8'h01);
    ss_high();
    chk("lsb_rx", rx_data, 8'h01);
    check_counts("lsb");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
